pwr_domain_resp: RTL and testbench

PWR_DOMAIN_RESP -- requirements
Module: pwr_domain_resp

---
 rtl/pwr_domain_resp_if.sv | 31 +++
 rtl/pwr_domain_resp.sv | 180 ++++++++++++++++++
 tb/tb_pwr_domain_resp.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwr_domain_resp_if.sv
// Power-controller <-> domain responder signal bundle.
// Master = power controller side, slave = pwr_domain_resp.
// o_drain_tmo only exists when PD_RESP_TIMEOUT_EN is defined.
interface pwr_domain_resp_if;
  logic i_hw_sleep_req;
  logic i_pwr_on_req;
  logic i_busy;
  logic o_hw_sleep_ack;
  logic o_pwr_on_ack;
`ifdef PD_RESP_TIMEOUT_EN
  logic o_drain_tmo;

  modport master (
    output i_hw_sleep_req, i_pwr_on_req, i_busy,
    input  o_hw_sleep_ack, o_pwr_on_ack, o_drain_tmo
  );
  modport slave (
    input  i_hw_sleep_req, i_pwr_on_req, i_busy,
    output o_hw_sleep_ack, o_pwr_on_ack, o_drain_tmo
  );
`else
  modport master (
    output i_hw_sleep_req, i_pwr_on_req, i_busy,
    input  o_hw_sleep_ack, o_pwr_on_ack
  );
  modport slave (
    input  i_hw_sleep_req, i_pwr_on_req, i_busy,
    output o_hw_sleep_ack, o_pwr_on_ack
  );
`endif
endinterface

// File: rtl/pwr_domain_resp.sv
// Power-domain responder: 4-phase sleep handshake (AWAKE/DRAIN/ACKED) and
// power-switch ramp tracker (ON/RAMP_DN/OFF/RAMP_UP) with power-good ack.
// Optional feature macro: PD_RESP_TIMEOUT_EN adds a DRAIN timeout that forces
// the sleep ack and raises the sticky o_drain_tmo flag.
module pwr_domain_resp #(
  parameter int unsigned RAMP_UP_CYC   = 4,
  parameter int unsigned RAMP_DN_CYC   = 2,
  parameter int unsigned DRAIN_TMO_CYC = 16
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst,
  pwr_domain_resp_if.slave pd
);

  localparam int unsigned CW = $clog2(255 + 1);

  // An out-of-range configuration collapses both ramps to a single cycle.
  localparam bit CFG_OK = (RAMP_UP_CYC >= 1) && (RAMP_UP_CYC <= 255) &&
                          (RAMP_DN_CYC >= 1) && (RAMP_DN_CYC <= 255) &&
                          (DRAIN_TMO_CYC >= 1);
  localparam logic [CW-1:0] UP_LOAD = CFG_OK ? CW'(RAMP_UP_CYC - 1) : '0;
  localparam logic [CW-1:0] DN_LOAD = CFG_OK ? CW'(RAMP_DN_CYC - 1) : '0;

  typedef enum logic [1:0] {AWAKE, DRAIN, ACKED} sleep_t;
  typedef enum logic [1:0] {ON, RAMP_DN, OFF, RAMP_UP} pwr_t;

  sleep_t        sleep_state, sleep_next;
  logic          sleep_ack, sleep_ack_next;
  logic          sleep_hold;
  pwr_t          pwr_state, pwr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pwr_ack, pwr_ack_next;

`ifdef PD_RESP_TIMEOUT_EN
  localparam int unsigned    TW       = $clog2(DRAIN_TMO_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(DRAIN_TMO_CYC - 1);
  logic [TW-1:0] tmr, tmr_next;
  logic          tmo, tmo_next;
`endif

  // Sleep handshake is frozen while the rail is off or still ramping up.
  assign sleep_hold = (pwr_state == OFF) || (pwr_state == RAMP_UP);

  // Sleep FSM registers.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      sleep_state <= AWAKE;
      sleep_ack   <= 1'b0;
`ifdef PD_RESP_TIMEOUT_EN
      tmr         <= '0;
      tmo         <= 1'b0;
`endif
    end else begin
      sleep_state <= sleep_next;
      sleep_ack   <= sleep_ack_next;
`ifdef PD_RESP_TIMEOUT_EN
      tmr         <= tmr_next;
      tmo         <= tmo_next;
`endif
    end
  end

  // Sleep FSM next state; a withdrawn request in DRAIN wins over idle traffic.
  always_comb begin
    sleep_next     = sleep_state;
    sleep_ack_next = sleep_ack;
`ifdef PD_RESP_TIMEOUT_EN
    tmr_next       = tmr;
    tmo_next       = tmo;
`endif
    if (!sleep_hold) begin
      case (sleep_state)
        AWAKE: begin
          if (pd.i_hw_sleep_req) begin
            sleep_next = DRAIN;
`ifdef PD_RESP_TIMEOUT_EN
            tmr_next   = '0;
`endif
          end
        end
        DRAIN: begin
          if (!pd.i_hw_sleep_req) begin
            sleep_next     = AWAKE;
            sleep_ack_next = 1'b0;
          end else if (!pd.i_busy) begin
            sleep_next     = ACKED;
            sleep_ack_next = 1'b1;
          end
`ifdef PD_RESP_TIMEOUT_EN
          else if (tmr == TMO_LAST) begin
            sleep_next     = ACKED;
            sleep_ack_next = 1'b1;
            tmo_next       = 1'b1;
          end else begin
            tmr_next = tmr + 1'b1;
          end
`endif
        end
        ACKED: begin
          if (!pd.i_hw_sleep_req) begin
            sleep_next     = AWAKE;
            sleep_ack_next = 1'b0;
          end
        end
        default: begin
          sleep_next     = AWAKE;
          sleep_ack_next = 1'b0;
        end
      endcase
    end
  end

  // Power FSM registers; the domain is powered at reset.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      pwr_state <= ON;
      cnt       <= '0;
      pwr_ack   <= 1'b1;
    end else begin
      pwr_state <= pwr_next;
      cnt       <= cnt_next;
      pwr_ack   <= pwr_ack_next;
    end
  end

  // Power FSM next state; a reversal beats completion and reloads a full count.
  always_comb begin
    pwr_next     = pwr_state;
    cnt_next     = cnt;
    pwr_ack_next = pwr_ack;
    case (pwr_state)
      ON: begin
        if (!pd.i_pwr_on_req) begin
          pwr_next = RAMP_DN;
          cnt_next = DN_LOAD;
        end
      end
      RAMP_DN: begin
        if (pd.i_pwr_on_req) begin
          pwr_next = RAMP_UP;
          cnt_next = UP_LOAD;
        end else if (cnt == '0) begin
          pwr_next     = OFF;
          pwr_ack_next = 1'b0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      OFF: begin
        if (pd.i_pwr_on_req) begin
          pwr_next = RAMP_UP;
          cnt_next = UP_LOAD;
        end
      end
      RAMP_UP: begin
        if (!pd.i_pwr_on_req) begin
          pwr_next = RAMP_DN;
          cnt_next = DN_LOAD;
        end else if (cnt == '0) begin
          pwr_next     = ON;
          pwr_ack_next = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        pwr_next     = ON;
        cnt_next     = '0;
        pwr_ack_next = 1'b1;
      end
    endcase
  end

  assign pd.o_hw_sleep_ack = sleep_ack;
  assign pd.o_pwr_on_ack   = pwr_ack;
`ifdef PD_RESP_TIMEOUT_EN
  assign pd.o_drain_tmo    = tmo;
`endif

endmodule

// File: tb/tb_pwr_domain_resp.sv
// Bench for pwr_domain_resp: table-driven vectors feed a scoreboard that is
// compared on the falling edge; reset cases are hand-written sequences.
// Edge numbering: edge 1 is the first rising edge after reset release.
// A vector at edge N drives its inputs 1 ns after edge N and lists the
// outputs expected between edge N and edge N+1.
module tb_pwr_domain_resp;

`ifdef PD_RESP_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sreq, preq, busy;
  int unsigned cyc;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pwr_domain_resp_if if_a ();
  pwr_domain_resp_if if_b ();

  assign if_a.i_hw_sleep_req = sreq;
  assign if_a.i_pwr_on_req   = preq;
  assign if_a.i_busy         = busy;
  assign if_b.i_hw_sleep_req = sreq;
  assign if_b.i_pwr_on_req   = preq;
  assign if_b.i_busy         = busy;

  pwr_domain_resp #(.RAMP_UP_CYC(4), .RAMP_DN_CYC(2), .DRAIN_TMO_CYC(16)) u_a (
    .i_aon_clk        (clk),
    .i_soc_pwr_on_rst (rst),
    .pd               (if_a)
  );

  pwr_domain_resp #(.RAMP_UP_CYC(4), .RAMP_DN_CYC(8), .DRAIN_TMO_CYC(16)) u_b (
    .i_aon_clk        (clk),
    .i_soc_pwr_on_rst (rst),
    .pd               (if_b)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int unsigned edge_n;
    logic        sreq, preq, busy;
    logic        sel_b;
    logic        exp_s, exp_p, exp_t;
  } vec_t;

  typedef struct {
    int unsigned edge_n;
    logic        sel_b;
    logic        exp_s, exp_p, exp_t;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  function automatic vec_t mk(input int unsigned e, input logic sr, input logic pr,
                              input logic bz, input logic b, input logic es,
                              input logic ep, input logic et);
    vec_t v;
    v.edge_n = e; v.sreq = sr; v.preq = pr; v.busy = bz;
    v.sel_b = b; v.exp_s = es; v.exp_p = ep; v.exp_t = et;
    return v;
  endfunction

  function automatic void check(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard consumer: compare every entry due at the current edge count.
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
      e = sb.pop_front();
      if (e.edge_n != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_stale: seen at edge %0d expected at edge %0d", e.name, cyc, e.edge_n);
      end else if (e.sel_b) begin
        check({e.name, "_b_sack"}, if_b.o_hw_sleep_ack, e.exp_s);
        check({e.name, "_b_pack"}, if_b.o_pwr_on_ack, e.exp_p);
`ifdef PD_RESP_TIMEOUT_EN
        check({e.name, "_b_tmo"}, if_b.o_drain_tmo, e.exp_t);
`endif
      end else begin
        check({e.name, "_a_sack"}, if_a.o_hw_sleep_ack, e.exp_s);
        check({e.name, "_a_pack"}, if_a.o_pwr_on_ack, e.exp_p);
`ifdef PD_RESP_TIMEOUT_EN
        check({e.name, "_a_tmo"}, if_a.o_drain_tmo, e.exp_t);
`endif
      end
    end
  end

  task automatic wait_edge(input int unsigned n, input string nm);
    int unsigned guard = 0;
    while (cyc < n && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL %s_edge_wait: at edge %0d expected edge %0d", nm, cyc, n);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sreq = 1'b0;
    preq = 1'b1;
    busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    foreach (tbl[i]) begin
      sb_t e;
      wait_edge(tbl[i].edge_n, tag);
      sreq = tbl[i].sreq;
      preq = tbl[i].preq;
      busy = tbl[i].busy;
      e.edge_n = tbl[i].edge_n;
      e.sel_b  = tbl[i].sel_b;
      e.exp_s  = tbl[i].exp_s;
      e.exp_p  = tbl[i].exp_p;
      e.exp_t  = tbl[i].exp_t;
      e.name   = $sformatf("%s@%0d", tag, tbl[i].edge_n);
      sb.push_back(e);
    end
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_drain: %0d entries left, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sreq = 1'b0; preq = 1'b1; busy = 1'b0;

    // Reset values.
    do_reset();
    check("rst_a_sack", if_a.o_hw_sleep_ack, 1'b0);
    check("rst_a_pack", if_a.o_pwr_on_ack, 1'b1);
    check("rst_b_pack", if_b.o_pwr_on_ack, 1'b1);
`ifdef PD_RESP_TIMEOUT_EN
    check("rst_a_tmo", if_a.o_drain_tmo, 1'b0);
`endif

    // Sleep handshake with idle domain: ack two edges after the request.
    tbl.delete();
    //            edge sreq preq busy b  sack pack tmo
    tbl.push_back(mk(10, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(11, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(12, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(20, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(21, 0, 1, 0, 0, 0, 1, 0));
    run_vecs("slp");

    // Busy domain: wait for traffic to drain, or time out at edge 27.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(10, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(26, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(27, 1, 1, 1, 0, TMO_EN, 1, TMO_EN));
    tbl.push_back(mk(30, 1, 1, 0, 0, TMO_EN, 1, TMO_EN));
    tbl.push_back(mk(31, 1, 1, 0, 0, 1, 1, TMO_EN));
    tbl.push_back(mk(32, 0, 1, 0, 0, 1, 1, TMO_EN));
    tbl.push_back(mk(33, 0, 1, 0, 0, 0, 1, TMO_EN));
    run_vecs("busy");

    // Request withdrawn during DRAIN: no ack.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(4, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(5, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(7, 0, 1, 0, 0, 0, 1, 0));
    run_vecs("wdraw");

    // Power off then on: req sampled at edge 5 / 20.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(6, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(19, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(23, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(24, 0, 1, 0, 0, 0, 1, 0));
    run_vecs("pwr");

    // Reversal on the 8-cycle ramp: ack stays 1, RAMP_UP ends at edge 11;
    // a sleep request held off by RAMP_UP is only accepted from edge 12.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(6, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(9, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(11, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(12, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(13, 1, 1, 0, 1, 1, 1, 0));
    run_vecs("rev");

    // Sleep ack held through a full power-off/on cycle.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(4, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(7, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(12, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(17, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(18, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(19, 0, 1, 0, 0, 0, 1, 0));
    run_vecs("hold");

    // Asynchronous reset in the middle of RAMP_UP with sleep acked.
    do_reset();
    wait_edge(1, "arst");
    sreq = 1'b1;
    wait_edge(3, "arst");
    check("arst_pre_sack", if_a.o_hw_sleep_ack, 1'b1);
    preq = 1'b0;
    wait_edge(6, "arst");
    check("arst_off_pack", if_a.o_pwr_on_ack, 1'b0);
    preq = 1'b1;
    wait_edge(8, "arst");
    check("arst_ramp_pack", if_a.o_pwr_on_ack, 1'b0);
    check("arst_ramp_sack", if_a.o_hw_sleep_ack, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pack", if_a.o_pwr_on_ack, 1'b1);
    check("arst_sack", if_a.o_hw_sleep_ack, 1'b0);
    check("arst_b_pack", if_b.o_pwr_on_ack, 1'b1);
`ifdef PD_RESP_TIMEOUT_EN
    check("arst_tmo", if_a.o_drain_tmo, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
